rtlmem_rdarb: RTL
=================

# rtlmem_rdarb

Round-robin read-port arbiter that shares the single read port of a 1R1W, 2-cycle-latency RTL memory wrapper among G_NREQ requesters in the rclk domain. It grants at most one read per cycle, drives the memory's memre/memra, and tracks each issued read through a tag pipeline matched to the memory latency. Returned data is steered back as a per-requester valid strobe on a shared data bus. It sits between client read engines and the memory wrapper's read port; the write port is not touched.

## Interface
Parameters:
- G_NREQ, 4, number of requesters (2..16)
- G_RDADDR, 10, memory read address width
- G_RDWIDTH, 16, memory read data width
- G_LATENCY, 2, memory read latency in rclk cycles (memre to memdo valid); must equal the wrapper pipeline

Ports:
- rclk  in  1  read clock
- rst_n  in  1  reset, synchronous, active-low
- rden  in  1  global read enable; low blocks new grants (used while memory clear is in progress)
- req  in  G_NREQ  per-requester read request, held until granted
- reqaddr  in  G_NREQ*G_RDADDR  flattened request addresses, requester i at [i*G_RDADDR +: G_RDADDR]
- gnt  out  G_NREQ  one-hot grant, same cycle as acceptance
- rvld  out  G_NREQ  one-hot return-data valid, aligned with rdat
- rdat  out  G_RDWIDTH  returned data, shared by all requesters
- busy  out  1  one or more reads in flight
- memre  out  1  to memory read enable
- memra  out  G_RDADDR  to memory read address
- memdo  in  G_RDWIDTH  from memory read data

## Operation
- Arbitration combinational each cycle: eligible = req & {G_NREQ{rden & rst_n}}; winner is the first eligible index searching upward from ptr+1 with wrap-around.
- gnt = one-hot winner (0 if none eligible); memre = |gnt; memra = reqaddr slice of winner, 0 when no grant.
- ptr register (index width clog2(G_NREQ)) updates to winner index on any grant; unchanged otherwise. Reset value G_NREQ-1, so requester 0 wins first after reset.
- Request rule: requester holds req and reqaddr stable until gnt; dropping req before gnt is legal and has no effect. Requester with req held after gnt requests again (back-to-back allowed).
- Tag pipeline: G_LATENCY stages of {vld, id}; stage 0 loads {memre, winner index}; each stage shifts every cycle unconditionally (no backpressure).
- Return: rvld[i] = last-stage vld & (last-stage id == i); rdat = memdo passed through combinationally.
- busy = OR of all stage vld bits.
- rden low: no new grants; in-flight reads still complete and return.
- Requesters must accept rvld/rdat unconditionally.

## Timing
- Reset (rst_n low at rclk edge): all tag stages vld=0, ptr=G_NREQ-1; during reset gnt=0, memre=0, memra=0, rvld=0, busy=0.
- Reset mid-operation: in-flight reads discarded, no rvld after reset release for reads issued before reset.
- Grant in cycle N -> memre high in cycle N -> rvld and valid rdat in cycle N+G_LATENCY (N+2 default).
- Throughput: one read per cycle sustained; single requester with req stuck high gets gnt every cycle.
- Fairness: with all G_NREQ requesting continuously, each granted exactly once per G_NREQ cycles.
- rden deasserted in cycle N: no gnt in N; returns of reads granted in N-1, N-2 still arrive.

## Structure
- Shared package rtlmem_pkg: clog2 function, requester-id width localparam derivation, tag record width constant.
- Sub-module rtlmem_rrarb: generic G_NREQ round-robin arbiter (req, enable -> one-hot gnt, index, ptr register). rtlmem_rdarb instantiates it plus the tag pipeline and address mux.

## Test plan
- Reset then req=4'b1111 continuously, distinct addresses -> gnt sequence 0001,0010,0100,1000,0001...; rvld follows same sequence 2 cycles later with rdat = memory content at each address.
- Only req[2] high for 5 cycles, addr 0x005 -> gnt[2] each cycle, memre 5 cycles, rvld[2] 5 consecutive cycles starting 2 cycles after first gnt.
- req=4'b1010 with ptr=1 -> gnt[3] first, then gnt[1], alternating; requesters 0,2 never granted.
- rden low while req=4'b0001 for 3 cycles, after one prior grant -> gnt=0 for 3 cycles, busy high 2 cycles then low, rvld[0] once only.
- rst_n asserted 1 cycle after grants to requesters 0 and 1 -> no rvld ever for those reads; after release first gnt goes to requester 0.
- Requester 3 drops req in cycle before its turn -> arbiter skips to next eligible, no memre for 3, ptr unchanged when no eligible.

Source files
------------

// File: rtl/rtlmem_pkg.sv
// Shared helpers for the rtlmem read-side blocks: index widths and the
// width of the {vld, id} tag that follows each read through the memory pipeline.
package rtlmem_pkg;

    localparam int C_MIN_NREQ = 2;
    localparam int C_MAX_NREQ = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    // Requester index width; never narrower than one bit.
    function automatic int id_width(input int nreq);
        return (clog2(nreq) < 1) ? 1 : clog2(nreq);
    endfunction

    // Tag record is {vld, id} with vld in the MSB.
    function automatic int tag_width(input int nreq);
        return 1 + id_width(nreq);
    endfunction

    localparam int C_TAG_W_MAX = 1 + clog2(C_MAX_NREQ);

endpackage

// File: rtl/rtlmem_rrarb.sv
// Generic round-robin arbiter: the first eligible requester above the last
// winner (with wrap) wins; the pointer only moves when something is granted.
module rtlmem_rrarb
    import rtlmem_pkg::*;
#(
    parameter  int G_NREQ = 4,
    localparam int C_IDW  = id_width(G_NREQ)
) (
    input  logic              rclk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [G_NREQ-1:0] i_req,
    output logic [G_NREQ-1:0] o_gnt,
    output logic [C_IDW-1:0]  o_idx
);

    logic [C_IDW-1:0]  r_ptr;
    logic [G_NREQ-1:0] w_elig;
    logic [C_IDW-1:0]  w_idx;
    logic              w_hit;
    int                w_c;

    // Reset gates eligibility so nothing is granted while rst_n is low.
    assign w_elig = i_req & {G_NREQ{i_en & rst_n}};

    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_c   = 0;
        for (int k = 1; k <= G_NREQ; k++) begin
            w_c = int'(r_ptr) + k;
            if (w_c >= G_NREQ) begin
                w_c = w_c - G_NREQ;
            end
            if (!w_hit && w_elig[w_c]) begin
                w_hit = 1'b1;
                w_idx = C_IDW'(w_c);
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        if (w_hit) begin
            o_gnt[w_idx] = 1'b1;
        end
    end

    assign o_idx = w_idx;

    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            r_ptr <= C_IDW'(G_NREQ - 1);
        end else if (w_hit) begin
            r_ptr <= w_idx;
        end
    end

endmodule

// File: rtl/rtlmem_rdarb.sv
// Shares the single read port of the 1R1W memory wrapper among G_NREQ
// requesters and steers returned data back with a per-requester valid strobe.
module rtlmem_rdarb
    import rtlmem_pkg::*;
#(
    parameter int G_NREQ    = 4,
    parameter int G_RDADDR  = 10,
    parameter int G_RDWIDTH = 16,
    parameter int G_LATENCY = 2
) (
    input  logic                       rclk,
    input  logic                       rst_n,
    input  logic                       i_rden,
    input  logic [G_NREQ-1:0]          i_req,
    input  logic [G_NREQ*G_RDADDR-1:0] i_reqaddr,
    output logic [G_NREQ-1:0]          o_gnt,
    output logic [G_NREQ-1:0]          o_rvld,
    output logic [G_RDWIDTH-1:0]       o_rdat,
    output logic                       o_busy,
    output logic                       o_memre,
    output logic [G_RDADDR-1:0]        o_memra,
    input  logic [G_RDWIDTH-1:0]       i_memdo
);

    localparam int C_IDW  = id_width(G_NREQ);
    localparam int C_TAGW = tag_width(G_NREQ);

    logic [G_NREQ-1:0]   w_gnt;
    logic [C_IDW-1:0]    w_idx;
    logic                w_memre;
    logic [G_RDADDR-1:0] w_memra;
    logic [C_TAGW-1:0]   r_tag [G_LATENCY];
    logic [C_TAGW-1:0]   w_last;
    logic                w_busy;

    rtlmem_rrarb #(
        .G_NREQ (G_NREQ)
    ) u_rrarb (
        .rclk  (rclk),
        .rst_n (rst_n),
        .i_en  (i_rden),
        .i_req (i_req),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_memre = |w_gnt;

    always_comb begin
        w_memra = '0;
        if (w_memre) begin
            w_memra = i_reqaddr[w_idx * G_RDADDR +: G_RDADDR];
        end
    end

    // Tags shift every cycle: the memory has no backpressure, so neither do we.
    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            for (int s = 0; s < G_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= {w_memre, w_idx};
            for (int s = 1; s < G_LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int s = 0; s < G_LATENCY; s++) begin
            w_busy = w_busy | r_tag[s][C_TAGW-1];
        end
    end

    assign w_last = r_tag[G_LATENCY-1];

    // Returns landing while reset is held belong to discarded reads.
    always_comb begin
        o_rvld = '0;
        for (int i = 0; i < G_NREQ; i++) begin
            o_rvld[i] = rst_n & w_last[C_TAGW-1] & (w_last[C_IDW-1:0] == C_IDW'(i));
        end
    end

    assign o_gnt   = w_gnt;
    assign o_memre = w_memre;
    assign o_memra = w_memra;
    assign o_rdat  = i_memdo;
    assign o_busy  = w_busy & rst_n;

endmodule
